// File: rtl/sccb_target.sv
// SCCB/I2C target emulating the OV7670 control port with a 256x8 register bank.
// Define SCCB_TGT_AUTOINC_EN to advance the register pointer after every data byte.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] PID_VAL  = 8'h76,
    parameter logic [7:0] VER_VAL  = 8'h73
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_wr_stb,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic [7:0] i_host_addr,
    output logic [7:0] o_host_data
);

`ifdef SCCB_TGT_AUTOINC_EN
    localparam logic [7:0] PTR_STEP = 8'd1;
`else
    localparam logic [7:0] PTR_STEP = 8'd0;
`endif
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_W, RDATA, RACK, WAIT_STOP
    } state_t;

    logic [1:0] raw_vec;
    logic [1:0] filt_vec;
    logic [1:0] prev_reg;

    assign raw_vec = {i_sda, i_scl};

    // Index 0 is SCL, index 1 is SDA; both reset to the idle-high bus level.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            logic [1:0]    sync_reg;
            logic          filt_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sync_reg <= 2'b11;
                    filt_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], raw_vec[gi]};
                    if (sync_reg[1] == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
                        filt_reg <= sync_reg[1];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign filt_vec[gi] = filt_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) prev_reg <= 2'b11;
        else       prev_reg <= filt_vec;
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_vec[0];
    assign sda_f     = filt_vec[1];
    assign scl_rise  = scl_f & ~prev_reg[0];
    assign scl_fall  = ~scl_f & prev_reg[0];
    assign start_det = scl_f & prev_reg[0] & prev_reg[1] & ~sda_f;
    assign stop_det  = scl_f & prev_reg[0] & ~prev_reg[1] & sda_f;

    state_t     state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] ptr_reg;
    logic       nack_reg;
    logic       oe_reg;
    logic       busy_reg;
    logic       wr_stb_reg;
    logic [7:0] wr_addr_reg;
    logic [7:0] wr_data_reg;
    logic [7:0] bank_reg [256];
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = bank_reg[ptr_reg];
        if (ptr_reg == 8'h0A) rd_byte = PID_VAL;
        if (ptr_reg == 8'h0B) rd_byte = VER_VAL;
        o_host_data = bank_reg[i_host_addr];
        if (i_host_addr == 8'h0A) o_host_data = PID_VAL;
        if (i_host_addr == 8'h0B) o_host_data = VER_VAL;
    end

    // A COM7 soft reset (bit 7 of register 0x12) clears the bank one cycle after its strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 256; i++) bank_reg[i] <= 8'h00;
        end else if (wr_stb_reg) begin
            if (wr_addr_reg == 8'h12 && wr_data_reg[7]) begin
                for (int i = 0; i < 256; i++) bank_reg[i] <= 8'h00;
            end else begin
                bank_reg[wr_addr_reg] <= wr_data_reg;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'h00;
            ptr_reg     <= 8'h00;
            nack_reg    <= 1'b0;
            oe_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            wr_stb_reg  <= 1'b0;
            wr_addr_reg <= 8'h00;
            wr_data_reg <= 8'h00;
        end else begin
            wr_stb_reg <= 1'b0;
            if (stop_det) begin
                state_reg <= IDLE;
                oe_reg    <= 1'b0;
                busy_reg  <= 1'b0;
            end else if (start_det) begin
                state_reg   <= DEV;
                oe_reg      <= 1'b0;
                bit_cnt_reg <= 4'd0;
            end else begin
                case (state_reg)
                    DEV, SUB, WDATA: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_f};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                            bit_cnt_reg <= 4'd0;
                            if (state_reg == DEV) begin
                                if (shift_reg[7:1] == DEV_ADDR) begin
                                    oe_reg    <= 1'b1;
                                    busy_reg  <= 1'b1;
                                    state_reg <= ACK_DEV;
                                end else begin
                                    busy_reg  <= 1'b0;
                                    state_reg <= WAIT_STOP;
                                end
                            end else if (state_reg == SUB) begin
                                ptr_reg   <= shift_reg;
                                oe_reg    <= 1'b1;
                                state_reg <= ACK_SUB;
                            end else begin
                                oe_reg    <= 1'b1;
                                state_reg <= ACK_W;
                                ptr_reg   <= ptr_reg + PTR_STEP;
                                if (ptr_reg != 8'h0A && ptr_reg != 8'h0B) begin
                                    wr_stb_reg  <= 1'b1;
                                    wr_addr_reg <= ptr_reg;
                                    wr_data_reg <= shift_reg;
                                end
                            end
                        end
                    end
                    ACK_DEV: begin
                        if (scl_fall) begin
                            bit_cnt_reg <= 4'd0;
                            if (shift_reg[0]) begin
                                shift_reg <= rd_byte;
                                oe_reg    <= ~rd_byte[7];
                                state_reg <= RDATA;
                            end else begin
                                oe_reg    <= 1'b0;
                                state_reg <= SUB;
                            end
                        end
                    end
                    ACK_SUB, ACK_W: begin
                        if (scl_fall) begin
                            oe_reg      <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg != 4'd0) begin
                            if (bit_cnt_reg == 4'd8) begin
                                oe_reg      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                ptr_reg     <= ptr_reg + PTR_STEP;
                                state_reg   <= RACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                oe_reg    <= ~shift_reg[6];
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            nack_reg    <= sda_f;
                            bit_cnt_reg <= 4'd1;
                        end else if (scl_fall && bit_cnt_reg != 4'd0) begin
                            bit_cnt_reg <= 4'd0;
                            if (!nack_reg) begin
                                shift_reg <= rd_byte;
                                oe_reg    <= ~rd_byte[7];
                                state_reg <= RDATA;
                            end else begin
                                state_reg <= WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe  = oe_reg;
    assign o_busy    = busy_reg;
    assign o_wr_stb  = wr_stb_reg;
    assign o_wr_addr = wr_addr_reg;
    assign o_wr_data = wr_data_reg;

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB master on an open-drain SDA model.
module tb_sccb_target;

    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       o_sda_oe, o_busy, o_wr_stb;
    logic [7:0] o_wr_addr, o_wr_data, host_addr, host_data;

    int         checks = 0;
    int         failures = 0;
    int         stb_cnt = 0;
    logic [7:0] stb_addr = 8'h00;
    logic [7:0] stb_data = 8'h00;
    logic       oe_seen = 1'b0;

    assign sda_bus = sda_m & ~o_sda_oe;

    sccb_target dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl),
        .i_sda       (sda_bus),
        .o_sda_oe    (o_sda_oe),
        .o_busy      (o_busy),
        .o_wr_stb    (o_wr_stb),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_host_addr (host_addr),
        .o_host_data (host_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_wr_stb) begin
            stb_cnt++;
            stb_addr = o_wr_addr;
            stb_data = o_wr_data;
        end
        if (o_sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        check(tag, host_data, exp);
    endtask

    task automatic bus_start;
        tick(Q); sda_m = 1'b1;
        tick(Q); scl = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl = 1'b0;
    endtask

    task automatic bus_stop;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tick(Q); sda_m = b;
        tick(Q); scl = 1'b1;
        tick(2 * Q); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); sda_m = 1'b1;
        tick(Q); scl = 1'b1;
        tick(Q); b = sda_bus;
        tick(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bit_v);
            d[i] = bit_v;
        end
        send_bit(nack);
    endtask

    // START, 0x42, sub-address, n data bytes, STOP; every byte must be ACKed.
    task automatic write_xfer(input string tag, input logic [7:0] sub,
                              input logic [7:0] d [4], input int n);
        logic ack;
        bus_start;
        write_byte(8'h42, ack); check({tag, ".ack_dev"}, ack, 1'b0);
        write_byte(sub, ack);   check({tag, ".ack_sub"}, ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], ack);
            check({tag, ".ack_data"}, ack, 1'b0);
        end
        bus_stop;
        $display("xfer %s: write sub=%02h bytes=%0d", tag, sub, n);
    endtask

    // START, 0x42, sub, Sr, 0x43, then n bytes read (last one NACKed), STOP.
    task automatic read_xfer(input string tag, input logic [7:0] sub,
                             input int n, output logic [7:0] d [4]);
        logic ack;
        bus_start;
        write_byte(8'h42, ack); check({tag, ".ack_dev"}, ack, 1'b0);
        write_byte(sub, ack);   check({tag, ".ack_sub"}, ack, 1'b0);
        bus_start;
        write_byte(8'h43, ack); check({tag, ".ack_rd"}, ack, 1'b0);
        for (int i = 0; i < n; i++) read_byte(i == n - 1, d[i]);
        bus_stop;
        $display("xfer %s: read sub=%02h d0=%02h", tag, sub, d[0]);
    endtask

    initial begin
        logic [7:0] rd [4];
        logic       ack;
        int         stb0;

        host_addr = 8'h00;
        tick(5);
        check("rst.oe", o_sda_oe, 1'b0);
        check("rst.busy", o_busy, 1'b0);
        check("rst.stb", o_wr_stb, 1'b0);
        check("rst.wr_addr", o_wr_addr, 8'h00);
        check("rst.wr_data", o_wr_data, 8'h00);
        peek("rst.bank00", 8'h00, 8'h00);
        peek("rst.pid", 8'h0A, 8'h76);
        peek("rst.ver", 8'h0B, 8'h73);
        rst = 1'b0;
        tick(5);

        // 1: plain write with busy observed mid-transfer
        bus_start;
        write_byte(8'h42, ack); check("t1.ack_dev", ack, 1'b0);
        check("t1.busy_mid", o_busy, 1'b1);
        write_byte(8'h17, ack); check("t1.ack_sub", ack, 1'b0);
        write_byte(8'h3A, ack); check("t1.ack_data", ack, 1'b0);
        bus_stop;
        $display("xfer t1: write 17=3A");
        check("t1.busy_end", o_busy, 1'b0);
        check("t1.stb_cnt", stb_cnt, 1);
        check("t1.stb_addr", stb_addr, 8'h17);
        check("t1.stb_data", stb_data, 8'h3A);
        peek("t1.bank17", 8'h17, 8'h3A);

        // 2: read-only PID register ignores writes, reads back PID
        write_xfer("t2w", 8'h0A, '{8'h55, 8'h00, 8'h00, 8'h00}, 1);
        check("t2.no_stb", stb_cnt, 1);
        peek("t2.bank0a", 8'h0A, 8'h76);
        read_xfer("t2r", 8'h0A, 1, rd);
        check("t2.pid_read", rd[0], 8'h76);
        read_xfer("t2r2", 8'h17, 2, rd);
        check("t2.rd17_0", rd[0], 8'h3A);
`ifdef SCCB_TGT_AUTOINC_EN
        check("t2.rd17_1", rd[1], 8'h00);
`else
        check("t2.rd17_1", rd[1], 8'h3A);
`endif

        // 3: foreign address is never acknowledged
        oe_seen = 1'b0;
        bus_start;
        write_byte(8'h60, ack); check("t3.nack", ack, 1'b1);
        write_byte(8'h17, ack); check("t3.nack2", ack, 1'b1);
        bus_stop;
        $display("xfer t3: address 60");
        check("t3.oe_never", oe_seen, 1'b0);
        check("t3.busy", o_busy, 1'b0);
        check("t3.no_stb", stb_cnt, 1);
        write_xfer("t3w", 8'h20, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1);
        peek("t3.bank20", 8'h20, 8'h5A);

        // 4: multi-byte write across the pointer wrap
        stb0 = stb_cnt;
        write_xfer("t4", 8'hFE, '{8'h11, 8'h22, 8'h33, 8'h00}, 3);
        check("t4.stb_cnt", stb_cnt - stb0, 3);
`ifdef SCCB_TGT_AUTOINC_EN
        peek("t4.bankFE", 8'hFE, 8'h11);
        peek("t4.bankFF", 8'hFF, 8'h22);
        peek("t4.bank00", 8'h00, 8'h33);
`else
        peek("t4.bankFE", 8'hFE, 8'h33);
        peek("t4.bankFF", 8'hFF, 8'h00);
        peek("t4.bank00", 8'h00, 8'h00);
`endif

        // 5: COM7 soft reset
        stb0 = stb_cnt;
        write_xfer("t5", 8'h12, '{8'h80, 8'h00, 8'h00, 8'h00}, 1);
        check("t5.stb_cnt", stb_cnt - stb0, 1);
        check("t5.stb_addr", stb_addr, 8'h12);
        check("t5.stb_data", stb_data, 8'h80);
        peek("t5.bank17", 8'h17, 8'h00);
        peek("t5.bank20", 8'h20, 8'h00);
        peek("t5.bank12", 8'h12, 8'h00);
        peek("t5.pid", 8'h0A, 8'h76);

        // 6: reset while the target drives read bit 7 (0 of 0x3A)
        write_xfer("t6w", 8'h17, '{8'h3A, 8'h00, 8'h00, 8'h00}, 1);
        bus_start;
        write_byte(8'h42, ack); check("t6.ack_dev", ack, 1'b0);
        write_byte(8'h17, ack); check("t6.ack_sub", ack, 1'b0);
        bus_start;
        write_byte(8'h43, ack); check("t6.ack_rd", ack, 1'b0);
        tick(Q);
        check("t6.driving", o_sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("t6.oe_rst", o_sda_oe, 1'b0);
        check("t6.busy_rst", o_busy, 1'b0);
        $display("xfer t6: reset during read");
        tick(3);
        rst = 1'b0;
        sda_m = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(4 * Q);
        check("t6.oe_idle", o_sda_oe, 1'b0);
        peek("t6.bank17", 8'h17, 8'h00);
        write_xfer("t6x", 8'h21, '{8'hC3, 8'h00, 8'h00, 8'h00}, 1);
        peek("t6.bank21", 8'h21, 8'hC3);
        check("t6.stb_addr", stb_addr, 8'h21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
